lane_key_debounce4: RTL
=======================

Name: lane_key_debounce4

Overview:
- Front-end conditioning stage for the four finger lanes.
- Takes raw mechanical key/button levels for 4 lanes, synchronises them to the system clock and debounces each lane independently.
- Produces clean lane levels plus single-cycle press and release pulses.
- Its 4-bit press vector feeds the downstream bitwise-OR lane merge, where it is combined with the other 4-bit hit source before hit judgement.

Parameters:
- TICK_DIV, 50000, clocks per debounce sample tick. At 50 MHz this is a 1 ms sample period. Legal range 1..2^20.
- STABLE_CNT, 10, consecutive sample ticks a changed input must persist before the output lane changes. Legal range 1..255.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- key_in  input  4  raw lane keys, active-high pressed, asynchronous to clk; bit i = lane i.
- key_level  output  4  debounced lane state, 1 = held.
- key_press  output  4  one-clk pulse per lane on debounced 0->1.
- key_release  output  4  one-clk pulse per lane on debounced 1->0.
- tick  output  1  debug: one-clk sample strobe.

Behaviour:
- Reset:
  - Asynchronous, active-low: asserting rst_n=0 immediately clears all state, regardless of clk.
  - Cleared state: key_level=0, key_press=0, key_release=0, tick=0, synchroniser flops=0, prescaler=0, all lane counters=0.
  - Release of rst_n is a normal synchronous restart. No pulses are generated at reset exit.
  - Reset mid-debounce discards the partial count.
- Synchroniser:
  - Two-flop chain per lane: key_in -> s1 -> s2.
  - Only s2 is used downstream.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps to 0.
  - tick is registered and equals 1 for exactly one clk when the count wraps, giving one tick every TICK_DIV clocks.
  - With TICK_DIV=1, tick is constantly 1 after the first post-reset clock.
- Per-lane counter:
  - Width is ceil(log2(STABLE_CNT+1)).
  - Evaluated only on clk edges where tick=1; otherwise held.
  - If s2[i]==key_level[i]: cnt[i]<=0 (any bounce back restarts qualification).
  - If s2[i]!=key_level[i] and cnt[i]<STABLE_CNT-1: cnt[i]<=cnt[i]+1.
  - If s2[i]!=key_level[i] and cnt[i]==STABLE_CNT-1: key_level[i]<=s2[i] and cnt[i]<=0.
- Pulses:
  - key_press[i] and key_release[i] are registered and asserted on the same edge that key_level[i] changes.
  - They are high for exactly one clk, then 0.
  - key_press and key_release are mutually exclusive per lane.
  - Lanes are fully independent. Any combination of lanes may change on the same tick, giving multiple bits set simultaneously.
- Latency:
  - From a clean key_in edge to the key_level change: at least 2+(STABLE_CNT-1)*TICK_DIV+1 clocks and at most 2+STABLE_CNT*TICK_DIV clocks.
  - The exact value within that window depends on prescaler phase.
- Glitch rule: a pulse shorter than (STABLE_CNT-1)*TICK_DIV clocks never changes key_level.
- Held key: key_press fires once only. No auto-repeat.
- Counter saturation: not possible, because the counter resets on qualification.

Test Plan:
- Reset: with TICK_DIV=4 and STABLE_CNT=3, drive rst_n=0 while key_in=4'b1111 -> all outputs 0 asynchronously. Release rst_n with key_in=4'b0000 -> outputs stay 0 for 100 clocks.
- Clean press on lane 2: key_in 0000->0100 -> key_level becomes 0100 within clocks 11..14 of the edge. key_press=0100 for exactly one clk on that same edge. key_release stays 0000.
- Bounce rejection: lane 0 toggles 1,0,1,0 every 3 clocks for 12 clocks, then settles at 0 -> key_level[0] stays 0, and no press or release pulse occurs.
- Simultaneous lanes: key_in 0000->1011 on one clk edge -> key_level goes to 1011 on a single edge with key_press=1011. Later key_in->0000 gives key_release=1011 for one clk.
- Reset mid-qualification: assert lane 1, then pull rst_n low 6 clocks later for 1 clk -> no key_press. After reset, requalification takes the full 11..14-clock window again.
- Long hold with defaults (TICK_DIV=50000, STABLE_CNT=10): press lane 3 for 2 ms -> no key_press. Hold for 12 ms -> exactly one key_press[3] pulse, and tick period measures 50000 clocks.

Source files
------------

// File: rtl/lane_key_debounce4.sv
// Purpose : synchronise and debounce four raw finger-lane keys; emit clean levels and press/release pulses.
// Latency : 2 sync clocks + STABLE_CNT sample ticks (window set by prescaler phase) from key edge to level change.
// Backpress: none; free-running conditioning stage, outputs are registered every clock.
module lane_key_debounce4 #(
    parameter int TICK_DIV   = 50000,
    parameter int STABLE_CNT = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] key_in,
    output logic [3:0] key_level,
    output logic [3:0] key_press,
    output logic [3:0] key_release,
    output logic       tick
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = $clog2(STABLE_CNT + 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CNT - 1);

    logic [3:0]         sync_s1;
    logic [3:0]         sync_s2;
    logic [PW-1:0]      pre_cnt;
    logic [3:0][CW-1:0] lane_cnt;

    // Two-flop synchroniser per lane; only the second stage is consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_s1 <= '0;
            sync_s2 <= '0;
        end else begin
            sync_s1 <= key_in;
            sync_s2 <= sync_s1;
        end
    end

    // Prescaler wraps every TICK_DIV clocks; tick is the registered wrap strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
            tick    <= 1'b0;
        end else if (pre_cnt == PRE_LAST) begin
            pre_cnt <= '0;
            tick    <= 1'b1;
        end else begin
            pre_cnt <= pre_cnt + PW'(1);
            tick    <= 1'b0;
        end
    end

    // Per-lane qualification: any sample matching the current level restarts the count,
    // the STABLE_CNT-th consecutive differing sample flips the level and fires one pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_cnt    <= '0;
            key_level   <= '0;
            key_press   <= '0;
            key_release <= '0;
        end else begin
            key_press   <= '0;
            key_release <= '0;
            if (tick) begin
                for (int i = 0; i < 4; i++) begin
                    if (sync_s2[i] == key_level[i]) begin
                        lane_cnt[i] <= '0;
                    end else if (lane_cnt[i] == CNT_LAST) begin
                        lane_cnt[i]    <= '0;
                        key_level[i]   <= sync_s2[i];
                        key_press[i]   <= sync_s2[i];
                        key_release[i] <= ~sync_s2[i];
                    end else begin
                        lane_cnt[i] <= lane_cnt[i] + CW'(1);
                    end
                end
            end
        end
    end

endmodule
